// File: rtl/jk_bank_writer.sv
// Write-side controller for a bank of level-sensitive JK latch cells.
// Derives hold/set/reset excitation from sampled Q, pulses the bank, then verifies and retries.
module jk_bank_writer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_clr,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic             latch_en,
  output logic             latch_rst,
  output logic [WIDTH-1:0] latch_j,
  output logic [WIDTH-1:0] latch_k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [2:0]       rsp_retries,
  output logic [WIDTH-1:0] rsp_q
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    DRIVE  = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic             clr_r;
  logic [WIDTH-1:0] data_r, mask_r;
  logic [WIDTH-1:0] target, target_nx;
  logic [WIDTH-1:0] j_r, k_r;
  logic [WIDTH-1:0] q_r;
  logic [3:0]       cnt;
  logic [2:0]       retries;
  logic             ok_r;
  logic             match;
  logic             can_retry;

  assign match       = (q_fb == target);
  assign can_retry   = (retries < 3'(MAX_RETRY));
  assign rsp_ok      = ok_r;
  assign rsp_retries = retries;
  assign rsp_q       = q_r;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    latch_en  = 1'b0;
    latch_rst = 1'b0;
    latch_j   = '0;
    latch_k   = '0;
    // The target is only derived on the first attempt; retries reuse the frozen value.
    target_nx = target;
    if (retries == '0)
      target_nx = clr_r ? '0 : ((q_fb & ~mask_r) | (data_r & mask_r));

    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = SAMPLE;
      end
      SAMPLE: state_nx = DRIVE;
      DRIVE: begin
        latch_en  = 1'b1;
        latch_rst = clr_r;
        if (!clr_r) begin
          latch_j = j_r;
          latch_k = k_r;
        end
        state_nx = SETTLE;
      end
      SETTLE: begin
        if (cnt <= 4'd1) state_nx = CHECK;
      end
      CHECK: begin
        if (match)          state_nx = RESP;
        else if (can_retry) state_nx = SAMPLE;
        else                state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clr_r   <= 1'b0;
      data_r  <= '0;
      mask_r  <= '0;
      target  <= '0;
      j_r     <= '0;
      k_r     <= '0;
      q_r     <= '0;
      cnt     <= '0;
      retries <= '0;
      ok_r    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            clr_r   <= req_clr;
            data_r  <= req_data;
            mask_r  <= req_mask;
            retries <= '0;
          end
        end
        SAMPLE: begin
          target <= target_nx;
          j_r    <= ~q_fb & target_nx;
          k_r    <= q_fb & ~target_nx;
        end
        DRIVE:  cnt <= 4'(SETTLE_CYCLES);
        SETTLE: cnt <= cnt - 4'd1;
        CHECK: begin
          q_r  <= q_fb;
          ok_r <= match;
          if (!match && can_retry) retries <= retries + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_writer.sv
// Scoreboard bench for jk_bank_writer with a behavioural JK latch bank model.
module tb_jk_bank_writer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_clr = 1'b0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] req_mask = '0;
  logic         latch_en, latch_rst;
  logic [W-1:0] latch_j, latch_k;
  logic [W-1:0] q_fb;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_ok;
  logic [2:0]   rsp_retries;
  logic [W-1:0] rsp_q;

  jk_bank_writer #(.WIDTH(W), .SETTLE_CYCLES(2), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_clr(req_clr),
    .req_data(req_data), .req_mask(req_mask),
    .latch_en(latch_en), .latch_rst(latch_rst), .latch_j(latch_j), .latch_k(latch_k),
    .q_fb(q_fb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_retries(rsp_retries), .rsp_q(rsp_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Latch bank model: a JK cell sets on J, clears on K, clears on rst; can ignore pulses or be stuck.
  logic [W-1:0] bank = '0;
  logic         preset = 1'b0;
  logic [W-1:0] preset_val = '0;
  int           ign_n = 0;
  logic         stuck = 1'b0;
  int           pulses = 0;
  assign q_fb = bank;

  always @(posedge clk) begin
    if (preset) begin
      bank   <= preset_val;
      pulses <= 0;
    end else if (latch_en) begin
      pulses <= pulses + 1;
      if (!stuck && pulses >= ign_n)
        bank <= latch_rst ? '0 : ((bank | latch_j) & ~latch_k);
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic ok; logic [2:0] ret; logic [W-1:0] q; int lat; } rsp_t;
  typedef struct { logic [W-1:0] j; logic [W-1:0] k; logic r; } drv_t;
  rsp_t exp_rsp[$];
  drv_t exp_drv[$];
  int   accept_cyc = 0;
  int   rsp_done = 0;

  // Monitor: samples on the falling edge, compares against queued expectations.
  logic         prev_valid = 1'b0, prev_ready = 1'b0;
  logic         h_ok;
  logic [2:0]   h_ret;
  logic [W-1:0] h_q;
  always @(negedge clk) begin
    if (!rst) begin
      if (latch_en) begin
        check("jk_exclusive", 32'(latch_j & latch_k), 32'd0);
        if (exp_drv.size() == 0) check("drive_unexpected", 32'd1, 32'd0);
        else begin
          drv_t d;
          d = exp_drv.pop_front();
          check("drive_j", 32'(latch_j), 32'(d.j));
          check("drive_k", 32'(latch_k), 32'(d.k));
          check("drive_rst", 32'(latch_rst), 32'(d.r));
        end
      end
      if (rsp_valid) begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (!prev_valid) begin
          if (exp_rsp.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
          else check("rsp_latency", 32'(cyc - accept_cyc), 32'(exp_rsp[0].lat));
        end else if (!prev_ready) begin
          check("rsp_stable", {20'd0, rsp_ok, rsp_retries, rsp_q}, {20'd0, h_ok, h_ret, h_q});
        end
        if (rsp_ready && exp_rsp.size() != 0) begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_ok", 32'(rsp_ok), 32'(e.ok));
          check("rsp_retries", 32'(rsp_retries), 32'(e.ret));
          check("rsp_q", 32'(rsp_q), 32'(e.q));
          rsp_done++;
        end
        h_ok = rsp_ok; h_ret = rsp_retries; h_q = rsp_q;
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] b, input int ign, input logic stk,
                       input logic clr, input logic [W-1:0] data, input logic [W-1:0] mask,
                       input logic [W-1:0] ej, input logic [W-1:0] ek, input int npulse,
                       input logic eok, input logic [2:0] eret, input logic [W-1:0] eq,
                       input logic push_rsp);
    rsp_t e;
    drv_t d;
    preset = 1'b1; preset_val = b; ign_n = ign; stuck = stk;
    step();
    preset = 1'b0;
    d.j = ej; d.k = ek; d.r = clr;
    for (int i = 0; i < npulse; i++) exp_drv.push_back(d);
    e.ok = eok; e.ret = eret; e.q = eq; e.lat = 5 * npulse;
    if (push_rsp) exp_rsp.push_back(e);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_clr = clr; req_data = data; req_mask = mask;
    accept_cyc = cyc + 1;
    step();
    req_valid = 1'b0; req_clr = 1'b0; req_data = '0; req_mask = '0;
  endtask

  task automatic wait_rsp(input int start);
    int n = 0;
    while (rsp_done == start && n < 200) begin step(); n++; end
    if (rsp_done == start) check("rsp_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_latch"}, {14'd0, latch_en, latch_rst, latch_j, latch_k}, 32'd0);
    check({tag, "_rsp"}, {20'd0, rsp_valid, rsp_ok, rsp_retries, rsp_q}, 32'd0);
  endtask

  initial begin
    int start;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Plain write into empty bank.
    start = rsp_done;
    issue(8'h00, 0, 1'b0, 1'b0, 8'hA5, 8'hFF, 8'hA5, 8'h00, 1, 1'b1, 3'd0, 8'hA5, 1'b1);
    wait_rsp(start);

    // Masked write: target (F0 & C3) | (0F & 3C) = CC.
    start = rsp_done;
    issue(8'hF0, 0, 1'b0, 1'b0, 8'h0F, 8'h3C, 8'h0C, 8'h30, 1, 1'b1, 3'd0, 8'hCC, 1'b1);
    wait_rsp(start);

    // Clear: reset line with enable, J=K=0.
    start = rsp_done;
    issue(8'h5A, 0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, 1'b1, 3'd0, 8'h00, 1'b1);
    wait_rsp(start);

    // Bank ignores two pulses: two retries then success.
    start = rsp_done;
    issue(8'h00, 2, 1'b0, 1'b0, 8'h3C, 8'hFF, 8'h3C, 8'h00, 3, 1'b1, 3'd2, 8'h3C, 1'b1);
    wait_rsp(start);

    // Stuck bank: 4 pulses, failure with saturated retry count.
    start = rsp_done;
    issue(8'h00, 0, 1'b1, 1'b0, 8'h81, 8'hFF, 8'h81, 8'h00, 4, 1'b0, 3'd3, 8'h00, 1'b1);
    wait_rsp(start);

    // Empty mask: hold pulse only.
    start = rsp_done;
    issue(8'h66, 0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 1'b1, 3'd0, 8'h66, 1'b1);
    wait_rsp(start);

    // Backpressure: response held, new request ignored, then single-cycle rsp_ready.
    rsp_ready = 1'b0;
    issue(8'h00, 0, 1'b0, 1'b0, 8'h12, 8'hF0, 8'h10, 8'h00, 1, 1'b1, 3'd0, 8'h10, 1'b1);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin step(); n++; end
      check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    end
    req_valid = 1'b1; req_clr = 1'b0; req_data = 8'hEE; req_mask = 8'hFF;
    repeat (10) step();
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0; req_data = '0; req_mask = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_idle_after", 32'(req_ready), 32'd1);
    check("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    check("bp_rsp_count", 32'(exp_rsp.size()), 32'd0);
    rsp_ready = 1'b1;
    repeat (3) step();

    // Reset during SETTLE: no response must follow.
    issue(8'h10, 0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hEF, 8'h00, 1, 1'b0, 3'd0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (20) step();

    // Recovery after abort: clear the now-full bank.
    start = rsp_done;
    issue(8'hFF, 0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b1, 3'd0, 8'h00, 1'b1);
    wait_rsp(start);

    check("drive_queue_drained", 32'(exp_drv.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
